// File: rtl/pc_fetch_sequencer.sv
// Fetch-PC owner and instruction-memory request sequencer for the front end.
// Applies branch-unit redirects, discards wrong-path responses and flushes IF/ID.
module pc_fetch_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       action,
  input  logic [WIDTH-1:0] target,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_valid,
  input  logic [31:0]      imem_data,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             flush,
  output logic             misalign
);

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [WIDTH-1:0]     instr_pc_q, instr_pc_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 flush_q, flush_d;
  logic                 misalign_q, misalign_d;
  logic                 imem_req_q, imem_req_d;
  logic                 redirect;

  assign redirect = (action == 2'd2) || (action == 2'd3);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_REQ;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      imem_req_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      imem_req_q    <= imem_req_d;
    end
  end

  // Next state; a redirect overrides stall and normal sequencing in every state
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;

    if (redirect) begin
      fetch_pc_d    = {target[WIDTH-1:2], 2'b00};
      flush_d       = 1'b1;
      misalign_d    = |target[1:0];
      instr_valid_d = 1'b0;
      // An accepted-but-unanswered request must be drained before reissuing
      case (state_q)
        ST_REQ:   state_d = imem_ready ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = imem_valid ? ST_REQ : ST_DRAIN;
        ST_HOLD:  state_d = ST_REQ;
        ST_DRAIN: state_d = imem_valid ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_ready) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid) begin
            instr_d       = imem_data;
            instr_pc_d    = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + WIDTH'(4);
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instr_valid_d = 1'b0;
            state_d       = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_valid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  assign imem_req_d = (state_d == ST_REQ);

  assign imem_req    = imem_req_q;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: a latency-programmable memory model answers
// requests; expected request addresses and delivered instructions are queued up front.
module tb_pc_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  action;
  logic [31:0] target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        flush;
  logic        misalign;

  pc_fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .action      (action),
    .target      (target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .flush       (flush),
    .misalign    (misalign)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_seen  = 0;
  int          lat     = 1;
  logic        prev_iv = 1'b0;
  logic        pend    = 1'b0;
  logic [31:0] pend_addr;
  int          pend_wait;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  function automatic logic [31:0] word_of(input logic [31:0] p);
    return p ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: score the accept, advance the memory model, then score delivered instructions
  task automatic tick();
    logic        acc;
    logic        r;
    logic [31:0] a;
    acc = imem_req && imem_ready && !reset;
    a   = imem_addr;
    r   = reset;
    if (acc) begin
      if (exp_addr.size() == 0) check("addr_extra", 32'(exp_addr.size()), 32'd1);
      else check("req_addr", a, exp_addr.pop_front());
    end
    @(posedge clock);
    #1;
    if (r) begin
      pend       = 1'b0;
      imem_valid = 1'b0;
    end else begin
      imem_valid = 1'b0;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = a;
        pend_wait = lat - 1;
      end else if (pend) begin
        pend_wait--;
      end
      if (pend && pend_wait == 0) begin
        imem_valid = 1'b1;
        imem_data  = word_of(pend_addr);
        pend       = 1'b0;
      end
    end
    @(negedge clock);
    if (instr_valid && !prev_iv) begin
      n_seen++;
      if (exp_pc.size() == 0) check("instr_extra", 32'(exp_pc.size()), 32'd1);
      else begin
        logic [31:0] p;
        p = exp_pc.pop_front();
        check("instr_pc", instr_pc, p);
        check("instr", instr, word_of(p));
      end
    end
    prev_iv = instr_valid;
  endtask

  task automatic run_instrs(input int n);
    int goal;
    int budget;
    goal   = n_seen + n;
    budget = 0;
    while (n_seen < goal && budget < 40) begin
      tick();
      budget++;
    end
    if (n_seen < goal) check("instr_timeout", 32'(n_seen), 32'(goal));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    imem_ready = 1'b0;
    action     = 2'd0;
    stall      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    target     = 32'h0;
    imem_valid = 1'b0;
    imem_data  = 32'h0;
    do_reset();
    check("rst_iv", 32'(instr_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", imem_addr, 32'h0);

    // Sequential fetch with Inc on action (no effect expected)
    action     = 2'd1;
    imem_ready = 1'b1;
    lat        = 1;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    exp_pc.push_back(32'h0);   exp_pc.push_back(32'h4);   exp_pc.push_back(32'h8);
    run_instrs(3);
    imem_ready = 1'b0;
    action     = 2'd0;

    // Stall four cycles holding instr_pc 0x4
    do_reset();
    imem_ready = 1'b1;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    exp_pc.push_back(32'h0);   exp_pc.push_back(32'h4);
    run_instrs(2);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_iv", 32'(instr_valid), 32'd1);
      check("stall_pc", instr_pc, 32'h4);
      check("stall_instr", instr, word_of(32'h4));
      check("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    check("post_stall_req", 32'(imem_req), 32'd1);
    check("post_stall_addr", imem_addr, 32'h8);
    exp_addr.push_back(32'h8); exp_pc.push_back(32'h8);
    run_instrs(1);
    imem_ready = 1'b0;

    // Branch in WAIT, response two cycles later is discarded
    do_reset();
    imem_ready = 1'b1;
    lat        = 3;
    exp_addr.push_back(32'h0);
    tick();
    check("wait_req", 32'(imem_req), 32'd0);
    action     = 2'd3;
    target     = 32'h100;
    imem_ready = 1'b0;
    tick();
    check("br_flush", 32'(flush), 32'd1);
    check("br_misalign", 32'(misalign), 32'd0);
    check("br_req", 32'(imem_req), 32'd0);
    action = 2'd0;
    tick();
    check("br_flush_once", 32'(flush), 32'd0);
    check("drain_req", 32'(imem_req), 32'd0);
    tick();
    check("br_req2", 32'(imem_req), 32'd1);
    check("br_addr", imem_addr, 32'h100);
    check("br_iv", 32'(instr_valid), 32'd0);
    lat        = 1;
    imem_ready = 1'b1;
    exp_addr.push_back(32'h100); exp_pc.push_back(32'h100);
    run_instrs(1);
    imem_ready = 1'b0;

    // Misaligned jump while stalled in HOLD
    stall = 1'b1;
    tick();
    check("hold_iv", 32'(instr_valid), 32'd1);
    action = 2'd2;
    target = 32'h203;
    tick();
    check("jmp_flush", 32'(flush), 32'd1);
    check("jmp_misalign", 32'(misalign), 32'd1);
    check("jmp_iv", 32'(instr_valid), 32'd0);
    check("jmp_req", 32'(imem_req), 32'd1);
    check("jmp_addr", imem_addr, 32'h200);
    action = 2'd0;
    stall  = 1'b0;
    tick();
    check("jmp_flush_once", 32'(flush), 32'd0);
    check("jmp_misalign_once", 32'(misalign), 32'd0);
    check("jmp_addr_stable", imem_addr, 32'h200);
    imem_ready = 1'b1;
    exp_addr.push_back(32'h200); exp_pc.push_back(32'h200);
    run_instrs(1);
    imem_ready = 1'b0;

    // Redirect in REQ while the old address is accepted -> drain
    tick();
    check("req_addr_204", imem_addr, 32'h204);
    imem_ready = 1'b1;
    action     = 2'd3;
    target     = 32'h300;
    exp_addr.push_back(32'h204);
    tick();
    check("reqacc_flush", 32'(flush), 32'd1);
    check("reqacc_req", 32'(imem_req), 32'd0);
    action     = 2'd0;
    imem_ready = 1'b0;
    tick();
    check("reqacc_req2", 32'(imem_req), 32'd1);
    check("reqacc_addr", imem_addr, 32'h300);
    check("reqacc_iv", 32'(instr_valid), 32'd0);
    imem_ready = 1'b1;
    exp_addr.push_back(32'h300); exp_pc.push_back(32'h300);
    run_instrs(1);
    imem_ready = 1'b0;

    // Back-to-back redirects: last wins, flush each cycle
    action = 2'd2;
    target = 32'h400;
    tick();
    check("b2b_flush1", 32'(flush), 32'd1);
    check("b2b_addr1", imem_addr, 32'h400);
    action = 2'd3;
    target = 32'h500;
    tick();
    check("b2b_flush2", 32'(flush), 32'd1);
    check("b2b_addr2", imem_addr, 32'h500);
    action = 2'd0;
    tick();
    check("b2b_flush3", 32'(flush), 32'd0);
    check("b2b_addr3", imem_addr, 32'h500);
    imem_ready = 1'b1;
    exp_addr.push_back(32'h500); exp_pc.push_back(32'h500);
    run_instrs(1);
    imem_ready = 1'b0;

    // PC wrap at the top of the address space
    action = 2'd2;
    target = 32'hFFFF_FFFC;
    tick();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    action     = 2'd0;
    imem_ready = 1'b1;
    exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0);
    exp_pc.push_back(32'hFFFF_FFFC);   exp_pc.push_back(32'h0);
    run_instrs(2);
    imem_ready = 1'b0;

    // Reset asserted while waiting on a response
    tick();
    check("pre_rst_addr", imem_addr, 32'h4);
    imem_ready = 1'b1;
    lat        = 3;
    exp_addr.push_back(32'h4);
    tick();
    check("wait2_req", 32'(imem_req), 32'd0);
    reset      = 1'b1;
    imem_ready = 1'b0;
    tick();
    check("mid_rst_iv", 32'(instr_valid), 32'd0);
    check("mid_rst_req", 32'(imem_req), 32'd1);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_pc", instr_pc, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_iv", 32'(instr_valid), 32'd0);

    check("sb_addr_left", 32'(exp_addr.size()), 32'd0);
    check("sb_pc_left", 32'(exp_pc.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
